n64_poll_scheduler: RTL

N64_POLL_SCHEDULER -- requirements
Module: n64_poll_scheduler

---
 rtl/n64_pkg.sv | 15 +
 rtl/n64_bit_tx.sv | 43 ++++
 rtl/n64_poll_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/n64_pkg.sv
// N64 controller poll scheduler: shared constants and state encoding.
package n64_pkg;
  localparam int BIT_CLKS  = 16;
  localparam int SHORT_LOW = 4;
  localparam int LONG_LOW  = 12;
  localparam int STOP_LOW  = 4;
  localparam logic [7:0] CMD_POLL = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    TX_BIT,
    TX_STOP,
    RX_WAIT
  } state_t;
endpackage

// File: rtl/n64_bit_tx.sv
// One N64 line bit: 16 clk_4M cycles, low for 4 ('1') or 12 ('0').
module n64_bit_tx
  import n64_pkg::*;
(
  input  logic clk_4M,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic oe,
  output logic done
);
  logic       active;
  logic       bval;
  logic [3:0] cnt;
  logic [3:0] nxt;
  logic [4:0] low_len;

  assign nxt     = cnt + 4'd1;
  assign low_len = bval ? 5'(SHORT_LOW) : 5'(LONG_LOW);
  assign done    = active && (cnt == 4'(BIT_CLKS - 1));

  // start may coincide with done so back-to-back bits leave no gap
  always_ff @(posedge clk_4M) begin
    if (reset) begin
      active <= 1'b0;
      bval   <= 1'b0;
      cnt    <= 4'd0;
      oe     <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      bval   <= bit_val;
      cnt    <= 4'd0;
      oe     <= 1'b1;
    end else if (done) begin
      active <= 1'b0;
      cnt    <= 4'd0;
      oe     <= 1'b0;
    end else if (active) begin
      cnt <= nxt;
      oe  <= {1'b0, nxt} < low_len;
    end
  end
endmodule

// File: rtl/n64_poll_scheduler.sv
// Periodic N64 controller poll: send command byte + stop bit,
// then wait for the receiver's word-complete strobe or time out.
module n64_poll_scheduler
  import n64_pkg::*;
#(
  parameter int         POLL_PERIOD = 66667,
  parameter int         RX_TIMEOUT  = 800,
  parameter logic [7:0] CMD         = CMD_POLL
) (
  input  logic       clk_4M,
  input  logic       reset,
  input  logic       poll_en,
  input  logic       rx_done_in,
  output logic       dout_oe,
  output logic       rx_enable,
  output logic       busy,
  output logic       poll_ok,
  output logic       poll_timeout,
  output logic [7:0] err_count
);
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [2:0]    idx;
  logic [1:0]    scnt;
  logic          stop_oe;
  logic          s1, s2, s3;
  logic          rx_edge;
  logic          wrap;
  logic          bit_start;
  logic [2:0]    nidx;
  logic          bit_oe;
  logic          bit_done;

  assign rx_edge   = s2 & ~s3;
  assign wrap      = poll_en && (pcnt == PW'(POLL_PERIOD - 1));
  assign nidx      = (state == IDLE) ? 3'd7 : idx - 3'd1;
  assign bit_start = ((state == IDLE) && wrap) ||
                     ((state == TX_BIT) && bit_done && (idx != 3'd0));

  n64_bit_tx u_bit_tx (
    .clk_4M  (clk_4M),
    .reset   (reset),
    .start   (bit_start),
    .bit_val (CMD[nidx]),
    .oe      (bit_oe),
    .done    (bit_done)
  );

  assign dout_oe   = bit_oe | stop_oe;
  assign rx_enable = (state == RX_WAIT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_4M) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rx_done_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk_4M) begin
    if (reset) begin
      state        <= IDLE;
      pcnt         <= '0;
      tcnt         <= '0;
      idx          <= 3'd0;
      scnt         <= 2'd0;
      stop_oe      <= 1'b0;
      poll_ok      <= 1'b0;
      poll_timeout <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      poll_ok      <= 1'b0;
      poll_timeout <= 1'b0;
      if (!poll_en || wrap) pcnt <= '0;
      else                  pcnt <= pcnt + PW'(1);
      unique case (state)
        IDLE: begin
          if (wrap) begin
            state <= TX_BIT;
            idx   <= 3'd7;
          end
        end
        TX_BIT: begin
          if (bit_done) begin
            if (idx == 3'd0) begin
              state   <= TX_STOP;
              stop_oe <= 1'b1;
              scnt    <= 2'd0;
            end else begin
              idx <= idx - 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (scnt == 2'(STOP_LOW - 1)) begin
            state   <= RX_WAIT;
            stop_oe <= 1'b0;
            tcnt    <= '0;
          end else begin
            scnt <= scnt + 2'd1;
          end
        end
        RX_WAIT: begin
          // a response arriving on the last timeout cycle still counts
          if (rx_edge) begin
            poll_ok <= 1'b1;
            state   <= IDLE;
          end else if (tcnt == TW'(RX_TIMEOUT - 1)) begin
            poll_timeout <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
